pc_next_sequencer: RTL and testbench

- Owns the program counter and drives instruction-fetch addresses through a valid/ready handshake.
- Computes redirect targets:
  - branch: PC+4 plus the sign-extended 16-bit offset shifted left two;
  - jump: 26-bit target shifted left two;
  - register jump.
- Sequences redirects, stalls and wrong-path flushes.
- Sits between the decode/control unit and instruction memory; replaces the free-running PC register and next-PC adder.

---
 rtl/pc_next_sequencer_pkg.sv | 22 ++
 rtl/pc_next_sequencer_if.sv | 33 +++
 rtl/pc_next_sequencer_target_calc.sv | 42 ++++
 rtl/pc_next_sequencer.sv | 121 ++++++++++++
 tb/tb_pc_next_sequencer.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/pc_next_sequencer_pkg.sv
// Shared types and constants for the program-counter sequencer.
package pc_seq_pkg;

    // Program-counter / fetch address width
    localparam int PC_W = 32;

    // Default first fetch address after reset
    localparam logic [PC_W-1:0] RESET_PC_DEF = 32'h0000_0000;

    // Redirect request types carried on ctrl_type_i (3 is reserved)
    localparam logic [1:0] BR = 2'd0;
    localparam logic [1:0] J  = 2'd1;
    localparam logic [1:0] JR = 2'd2;

    // Sequencer states
    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } state_e;

endpackage

// File: rtl/pc_next_sequencer_if.sv
// Fetch handshake toward instruction memory plus redirect requests from decode/control.
interface pc_next_sequencer_if;
    import pc_seq_pkg::*;

    logic            fetch_valid_o;
    logic [PC_W-1:0] fetch_addr_o;
    logic            fetch_ready_i;

    logic            ctrl_valid_i;
    logic [1:0]      ctrl_type_i;
    logic            ctrl_taken_i;
    logic [PC_W-1:0] ctrl_pc_i;
    logic [15:0]     ctrl_imm_i;
    logic [25:0]     ctrl_tgt_i;
    logic [PC_W-1:0] ctrl_rs_i;

    // Sequencer side: drives fetch, consumes redirects
    modport master (
        output fetch_valid_o, fetch_addr_o,
        input  fetch_ready_i,
        input  ctrl_valid_i, ctrl_type_i, ctrl_taken_i, ctrl_pc_i,
        input  ctrl_imm_i, ctrl_tgt_i, ctrl_rs_i
    );

    // Environment side: instruction memory and decode/control
    modport slave (
        input  fetch_valid_o, fetch_addr_o,
        output fetch_ready_i,
        output ctrl_valid_i, ctrl_type_i, ctrl_taken_i, ctrl_pc_i,
        output ctrl_imm_i, ctrl_tgt_i, ctrl_rs_i
    );

endinterface

// File: rtl/pc_next_sequencer_target_calc.sv
// Combinational redirect-target arithmetic: branch, jump and jump-register.
module pc_target_calc
    import pc_seq_pkg::*;
(
    input  logic [1:0]      ctrl_type_i,
    input  logic [PC_W-1:0] ctrl_pc_i,
    input  logic [15:0]     ctrl_imm_i,
    input  logic [25:0]     ctrl_tgt_i,
    input  logic [PC_W-1:0] ctrl_rs_i,
    output logic [PC_W-1:0] target_o,
    output logic            misalign_o
);

    logic        [PC_W-1:0] p4;
    logic signed [PC_W-1:0] br_off;
    logic        [PC_W-1:0] br_tgt;
    logic        [PC_W-1:0] j_tgt;
    logic        [PC_W-1:0] jr_tgt;

    // Word offset sign-extended and scaled to bytes; sums wrap modulo 2^32
    assign p4     = ctrl_pc_i + PC_W'(4);
    assign br_off = {{14{ctrl_imm_i[15]}}, ctrl_imm_i, 2'b00};
    assign br_tgt = p4 + br_off;
    assign j_tgt  = {p4[31:28], ctrl_tgt_i, 2'b00};
    assign jr_tgt = {ctrl_rs_i[31:2], 2'b00};

    // Select the target for the request type; reserved type falls back to p4
    always_comb begin
        target_o   = p4;
        misalign_o = 1'b0;
        case (ctrl_type_i)
            BR:      target_o = br_tgt;
            J:       target_o = j_tgt;
            JR: begin
                target_o   = jr_tgt;
                misalign_o = (ctrl_rs_i[1:0] != 2'b00);
            end
            default: target_o = p4;
        endcase
    end

endmodule

// File: rtl/pc_next_sequencer.sv
// Program counter owner: issues fetch addresses and applies redirects, stalls and flushes.
module pc_next_sequencer
    import pc_seq_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF,
    parameter int          AW       = PC_W
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                stall_i,
    pc_next_sequencer_if.master bus,
    output logic                flush_o,
    output logic                misalign_o,
    output logic [AW-1:0]       pc_o
);

    state_e          state_q, state_d;
    logic [AW-1:0]   pc_q, pc_d;
    logic            pend_q, pend_d;
    logic [AW-1:0]   pend_tgt_q, pend_tgt_d;
    logic            flush_q, flush_d;
    logic            misalign_q, misalign_d;

    logic [AW-1:0]   calc_tgt;
    logic            calc_mis;
    logic            req_ok;
    logic            capture;
    logic            redir_vld;
    logic [AW-1:0]   redir_tgt;
    logic            accept;

    pc_target_calc u_calc (
        .ctrl_type_i (bus.ctrl_type_i),
        .ctrl_pc_i   (bus.ctrl_pc_i),
        .ctrl_imm_i  (bus.ctrl_imm_i),
        .ctrl_tgt_i  (bus.ctrl_tgt_i),
        .ctrl_rs_i   (bus.ctrl_rs_i),
        .target_o    (calc_tgt),
        .misalign_o  (calc_mis)
    );

    // A request redirects only for jumps and taken branches; the oldest pending one wins
    assign req_ok    = bus.ctrl_valid_i &&
                       ((bus.ctrl_type_i == J) || (bus.ctrl_type_i == JR) ||
                        ((bus.ctrl_type_i == BR) && bus.ctrl_taken_i));
    assign capture   = req_ok && !pend_q;
    assign redir_vld = pend_q || capture;
    assign redir_tgt = pend_q ? pend_tgt_q : calc_tgt;
    assign accept    = (state_q == FETCH) && bus.fetch_ready_i;

    // State register
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) state_q <= BOOT;
        else        state_q <= state_d;
    end

    // Next-state logic: a stall takes effect only once the outstanding fetch is accepted
    always_comb begin
        state_d = state_q;
        case (state_q)
            BOOT:    state_d = FETCH;
            FETCH:   if (accept) state_d = stall_i ? HOLD : FETCH;
            HOLD:    if (!stall_i) state_d = FETCH;
            default: state_d = BOOT;
        endcase
    end

    // Outputs: the address shown is always the PC, valid only while fetching
    always_comb begin
        bus.fetch_valid_o = (state_q == FETCH);
        bus.fetch_addr_o  = pc_q;
        pc_o              = pc_q;
        flush_o           = flush_q;
        misalign_o        = misalign_q;
    end

    // Next PC, pending redirect and one-cycle pulse generation
    always_comb begin
        pc_d       = pc_q;
        pend_d     = pend_q;
        pend_tgt_d = pend_tgt_q;
        flush_d    = 1'b0;
        misalign_d = capture && calc_mis;
        if (capture) begin
            pend_d     = 1'b1;
            pend_tgt_d = calc_tgt;
        end
        if (accept) begin
            if (redir_vld) begin
                // The address just accepted was on the wrong path
                pc_d    = redir_tgt;
                pend_d  = 1'b0;
                flush_d = 1'b1;
            end else begin
                pc_d = pc_q + AW'(4);
            end
        end else if ((state_q == HOLD) && !stall_i && redir_vld) begin
            // Nothing was issued during the stall, so no flush is needed
            pc_d   = redir_tgt;
            pend_d = 1'b0;
        end
    end

    // Datapath and pulse registers
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            pc_q       <= RESET_PC;
            pend_q     <= 1'b0;
            pend_tgt_q <= '0;
            flush_q    <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            pend_q     <= pend_d;
            pend_tgt_q <= pend_tgt_d;
            flush_q    <= flush_d;
            misalign_q <= misalign_d;
        end
    end

endmodule

// File: tb/tb_pc_next_sequencer.sv
// Directed bench for pc_next_sequencer with a scoreboard of expected fetch addresses.
module tb_pc_next_sequencer;
    import pc_seq_pkg::*;

    logic        clk;
    logic        rst_i;
    logic        stall_i;
    logic        flush_o;
    logic        misalign_o;
    logic [31:0] pc_o;

    int n_assert = 0;
    int n_fail   = 0;
    logic [31:0] exp_q[$];

    pc_next_sequencer_if bus ();

    pc_next_sequencer #(.RESET_PC(32'h0000_0000)) dut (
        .clk_i      (clk),
        .rst_i      (rst_i),
        .stall_i    (stall_i),
        .bus        (bus),
        .flush_o    (flush_o),
        .misalign_o (misalign_o),
        .pc_o       (pc_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_assert++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    // One clock: at the falling edge compare any accepted fetch against the scoreboard
    task automatic cyc();
        logic [31:0] e;
        @(negedge clk);
        if (bus.fetch_valid_o && bus.fetch_ready_i) begin
            if (exp_q.size() == 0) begin
                n_assert++;
                n_fail++;
                $error("FAIL unexpected_fetch: observed %h expected none", bus.fetch_addr_o);
            end else begin
                e = exp_q.pop_front();
                chk("fetch_addr", bus.fetch_addr_o, e);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_ctrl(input logic v, input logic [1:0] t, input logic tk,
                            input logic [31:0] pc, input logic [15:0] imm,
                            input logic [25:0] tgt, input logic [31:0] rs);
        bus.ctrl_valid_i = v;
        bus.ctrl_type_i  = t;
        bus.ctrl_taken_i = tk;
        bus.ctrl_pc_i    = pc;
        bus.ctrl_imm_i   = imm;
        bus.ctrl_tgt_i   = tgt;
        bus.ctrl_rs_i    = rs;
    endtask

    task automatic clr_ctrl();
        set_ctrl(1'b0, BR, 1'b0, 32'h0, 16'h0, 26'h0, 32'h0);
    endtask

    initial begin
        rst_i   = 1'b0;
        stall_i = 1'b0;
        bus.fetch_ready_i = 1'b1;
        clr_ctrl();
        cyc();
        cyc();
        chk("rst_valid", bus.fetch_valid_o, 0);
        chk("rst_pc", pc_o, 32'h0);
        chk("rst_flush", flush_o, 0);
        chk("rst_misalign", misalign_o, 0);

        // Reset release: one BOOT cycle, then sequential fetches
        rst_i = 1'b1;
        chk("boot_valid", bus.fetch_valid_o, 0);
        cyc();
        chk("fetch_valid", bus.fetch_valid_o, 1);
        chk("fetch_pc0", pc_o, 32'h0);
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h4);
        exp_q.push_back(32'h8);
        exp_q.push_back(32'hC);
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("seq_flush", flush_o, 0);
        end

        // Taken backward branch captured in the cycle of an accept
        exp_q.push_back(32'h10);
        exp_q.push_back(32'hFC);
        set_ctrl(1'b1, BR, 1'b1, 32'h100, 16'hFFFE, 26'h0, 32'h0);
        cyc();
        clr_ctrl();
        chk("br_flush", flush_o, 1);
        chk("br_pc", pc_o, 32'hFC);
        cyc();
        chk("br_flush_end", flush_o, 0);

        // Untaken branch and reserved type are ignored
        exp_q.push_back(32'h100);
        set_ctrl(1'b1, BR, 1'b0, 32'h100, 16'hFFFE, 26'h0, 32'h0);
        cyc();
        clr_ctrl();
        chk("nt_flush", flush_o, 0);
        chk("nt_pc", pc_o, 32'h104);
        exp_q.push_back(32'h104);
        set_ctrl(1'b1, 2'd3, 1'b1, 32'h100, 16'h0010, 26'h40, 32'h0);
        cyc();
        clr_ctrl();
        chk("rsv_flush", flush_o, 0);
        chk("rsv_pc", pc_o, 32'h108);

        // Jump keeps the upper nibble of pc+4
        exp_q.push_back(32'h108);
        set_ctrl(1'b1, J, 1'b0, 32'hF000_0010, 16'h0, 26'h0000040, 32'h0);
        cyc();
        clr_ctrl();
        chk("j_flush", flush_o, 1);
        chk("j_misalign", misalign_o, 0);
        chk("j_pc", pc_o, 32'hF000_0100);

        // Jump-register with low bits set: aligned target, misalign pulse
        exp_q.push_back(32'hF000_0100);
        set_ctrl(1'b1, JR, 1'b0, 32'h0, 16'h0, 26'h0, 32'h0000_2003);
        cyc();
        clr_ctrl();
        chk("jr_flush", flush_o, 1);
        chk("jr_misalign", misalign_o, 1);
        chk("jr_pc", pc_o, 32'h2000);
        exp_q.push_back(32'h2000);
        cyc();
        chk("jr_misalign_end", misalign_o, 0);
        chk("jr_flush_end", flush_o, 0);
        chk("jr_seq_pc", pc_o, 32'h2004);

        // Redirect while the fetch is not accepted: address held for three cycles
        bus.fetch_ready_i = 1'b0;
        set_ctrl(1'b1, J, 1'b0, 32'h0, 16'h0, 26'h0000100, 32'h0);
        cyc();
        clr_ctrl();
        for (int i = 0; i < 3; i++) begin
            chk("hold_valid", bus.fetch_valid_o, 1);
            chk("hold_addr", bus.fetch_addr_o, 32'h2004);
            if (i < 2) cyc();
        end
        bus.fetch_ready_i = 1'b1;
        exp_q.push_back(32'h2004);
        cyc();
        chk("nr_flush", flush_o, 1);
        chk("nr_pc", pc_o, 32'h400);
        exp_q.push_back(32'h400);
        cyc();
        chk("nr_flush_end", flush_o, 0);

        // Stall across an accept, redirect arrives during HOLD
        stall_i = 1'b1;
        exp_q.push_back(32'h404);
        cyc();
        chk("stall_valid", bus.fetch_valid_o, 0);
        chk("stall_pc", pc_o, 32'h408);
        set_ctrl(1'b1, BR, 1'b1, 32'h1000, 16'h0010, 26'h0, 32'h0);
        cyc();
        clr_ctrl();
        chk("stall_valid2", bus.fetch_valid_o, 0);
        chk("stall_pc_frozen", pc_o, 32'h408);
        cyc();
        chk("stall_valid3", bus.fetch_valid_o, 0);
        stall_i = 1'b0;
        cyc();
        chk("unstall_valid", bus.fetch_valid_o, 1);
        chk("unstall_pc", pc_o, 32'h1044);
        chk("unstall_flush", flush_o, 0);
        exp_q.push_back(32'h1044);
        cyc();
        chk("unstall_flush2", flush_o, 0);
        chk("unstall_seq_pc", pc_o, 32'h1048);

        // Two redirects back to back while not ready: the first wins
        bus.fetch_ready_i = 1'b0;
        set_ctrl(1'b1, J, 1'b0, 32'h0, 16'h0, 26'h0000200, 32'h0);
        cyc();
        set_ctrl(1'b1, BR, 1'b1, 32'h0, 16'h0100, 26'h0, 32'h0);
        cyc();
        clr_ctrl();
        chk("two_addr", bus.fetch_addr_o, 32'h1048);
        bus.fetch_ready_i = 1'b1;
        exp_q.push_back(32'h1048);
        cyc();
        chk("two_flush", flush_o, 1);
        chk("two_pc", pc_o, 32'h800);
        exp_q.push_back(32'h800);
        cyc();
        chk("two_seq_pc", pc_o, 32'h804);

        // Branch target arithmetic wraps past 2^32
        exp_q.push_back(32'h804);
        set_ctrl(1'b1, BR, 1'b1, 32'hFFFF_FFF8, 16'h0001, 26'h0, 32'h0);
        cyc();
        clr_ctrl();
        chk("wrap_flush", flush_o, 1);
        chk("wrap_pc", pc_o, 32'h0);
        exp_q.push_back(32'h0);
        cyc();
        chk("wrap_seq_pc", pc_o, 32'h4);

        // Reset during a stall with a pending redirect: redirect is lost
        stall_i = 1'b1;
        exp_q.push_back(32'h4);
        cyc();
        set_ctrl(1'b1, J, 1'b0, 32'h0, 16'h0, 26'h0000300, 32'h0);
        cyc();
        clr_ctrl();
        rst_i = 1'b0;
        #1;
        chk("mid_rst_pc", pc_o, 32'h0);
        chk("mid_rst_valid", bus.fetch_valid_o, 0);
        chk("mid_rst_flush", flush_o, 0);
        cyc();
        cyc();
        stall_i = 1'b0;
        rst_i = 1'b1;
        chk("rerst_boot_valid", bus.fetch_valid_o, 0);
        cyc();
        chk("rerst_valid", bus.fetch_valid_o, 1);
        chk("rerst_pc", pc_o, 32'h0);
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h4);
        cyc();
        chk("rerst_flush", flush_o, 0);
        cyc();
        chk("rerst_seq_pc", pc_o, 32'h8);

        chk("queue_drained", 32'(exp_q.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
